tcad_array: RTL and testbench
=============================

// Module: tcad_array
// PURPOSE
//  Reduced CGRA compute core: a 4x4 PE array with one LSU per row, a 1024x32 scratchpad (SPM),
//  a run sequencer and a result register. The host loads per-PE/LSU/SPM configuration words and
//  streams SPM data over the external bus; a run pulse pushes N iterations row by row.
//  Sits below the host-interface retiming stage; all inputs are already valid at the clock edge.
// PARAMETERS
//  A_W        10  SPM address width (1024 words)
//  DATA_W     32  datapath / SPM word width
//  PE_INST_W  48  configuration word width
//  ROWS/COLS  4/4 array geometry (fixed; decode below assumes 4x4)
// PORTS
//  clk              in   1   single clock, rising edge
//  rst              in   1   synchronous, active-high reset
//  host_controller  in   59  [58]run [57]init_SPM [56:53]init_row_0..3 [52]init_LSU [51:48]init_PE_0..3 [47:0]inst
//  ex_bus           in   44  [43]wen [42]ren [41:32]addr [31:0]data
//  TCAD_result      out  32  registered result / SPM read-back
// BEHAVIOUR
//  Reset: all config regs, spm_ctrl, sequencer (IDLE), valid pipeline, TCAD_result -> 0. SPM contents are not reset.
//  Config load (only in IDLE; ignored in RUN/DRAIN): for every asserted init_row_r:
//   init_PE_c -> pe_cfg[r][c] <= inst; init_LSU -> lsu_cfg[r] <= inst[15:0]. Multiple bits -> all selected load.
//   init_SPM -> spm_ctrl <= inst[23:0]; N = spm_ctrl[7:0] iteration count.
//  PE word: [3:0]op [47:16]imm. op 0 PASS, 1 x+imm, 2 x-imm, 3 (x*imm)[31:0], 4 AND, 5 OR, 6 XOR,
//   7 x<<imm[4:0], 8 x>>imm[4:0] logical, 9..15 PASS. All arithmetic mod 2^32.
//  LSU word: [9:0]base [13:10]stride [14]mode(0 load,1 store) [15]en. addr = (base + idx*stride) mod 1024.
//  Row r stage (1 cycle): in_r = (en&&load) ? spm[addr_r] (async read) : (r==0 ? 0 : row_out[r-1]);
//   PE chain c0->c3 combinational; row_out[r] <= chain(in_r); valid[r] <= valid_in_r; idx[r] <= idx_in_r.
//   valid_in_0/idx_in_0 from sequencer; valid_in_r = valid[r-1], idx_in_r = idx[r-1] for r>0.
//  Store: when valid[r] && en && store: spm[base + idx[r]*stride] <= row_out[r] (cycle after compute).
//  SPM write priority same cycle/same address: ex write lowest, then rows 0..3 (row 3 wins).
//  ex_bus: wen -> spm[addr] <= data at any time, any state.
//  Sequencer: IDLE --run && N!=0--> RUN (iter=0). RUN: issue valid_in_0=1, idx=iter each cycle, iter++;
//   after issuing iter N-1 -> DRAIN. DRAIN -> IDLE when valid[3:0]==0. run ignored outside IDLE; run with N==0 stays IDLE.
//  Latency: iteration k result in row_out[3] 4 cycles after issue; TCAD_result 1 cycle later.
//  TCAD_result: valid[3] -> row_out[3]; else ex_ren -> spm[ex_addr]; else hold.
//  rst mid-run: sequencer/pipeline squashed, no further stores.
// STRUCTURE
//  Shared package: host_controller/ex_bus bit positions, opcode and LSU-field constants, widths.
//  One natural sub-module: tcad_pe (combinational op(x, cfg) -> y), instantiated 16x.
//  Sequencer, valid/idx pipeline, config regs and SPM stay in tcad_array.
// TESTING
//  ex write spm[5]=0x1234, then ex_ren addr 5 -> TCAD_result=0x1234 next cycle.
//  Row0 LSU load base0 stride1, pe[0][0] ADD 1, others PASS; spm[i]=i+1 i=0..3, N=4, run ->
//   TCAD_result 2,3,4,5 on consecutive cycles starting 6 cycles after run sampled; then holds 5.
//  Row3 LSU store base 0x100 stride1 on same flow -> spm[0x100..0x103]=2..5 (check via ex_ren).
//  pe_cfg loads while RUN are ignored; run pulse during RUN ignored; N=0 -> stays IDLE, result unchanged.
//  MUL 0x10000*0x10000 -> 0; SHR imm 4 of 0x80000000 -> 0x08000000; addr base 0x3FF stride 2 idx1 -> 0x001.
//  rst asserted mid-RUN -> TCAD_result 0, IDLE, no stores after reset edge.

Source files
------------

// File: rtl/tcad_array_pkg.sv
// rtl/tcad_array_pkg.sv - shared constants and types for the tcad_array CGRA core
//
// Purpose : bit positions of the host_controller / ex_bus fields, datapath widths,
//           PE opcodes, LSU configuration layout, sequencer states and the LSU
//           address helper shared by the array top.
// Ports   : none (package)

package tcad_array_pkg;

   localparam int A_W        = 10;
   localparam int DATA_W     = 32;
   localparam int PE_INST_W  = 48;
   localparam int ROWS       = 4;
   localparam int COLS       = 4;
   localparam int SPM_DEPTH  = 1 << A_W;
   localparam int IDX_W      = 8;
   localparam int LSU_W      = 16;
   localparam int SPM_CTRL_W = 24;

   // host_controller layout
   localparam int HC_W        = 59;
   localparam int HC_RUN      = 58;
   localparam int HC_INIT_SPM = 57;
   localparam int HC_ROW_LSB  = 53;
   localparam int HC_INIT_LSU = 52;
   localparam int HC_PE_LSB   = 48;

   // ex_bus layout
   localparam int EX_W        = 44;
   localparam int EX_WEN      = 43;
   localparam int EX_REN      = 42;
   localparam int EX_ADDR_LSB = 32;

   typedef enum logic [3:0] {
      OP_PASS = 4'd0,
      OP_ADD  = 4'd1,
      OP_SUB  = 4'd2,
      OP_MUL  = 4'd3,
      OP_AND  = 4'd4,
      OP_OR   = 4'd5,
      OP_XOR  = 4'd6,
      OP_SHL  = 4'd7,
      OP_SHR  = 4'd8
   } pe_op_e;

   // Field order mirrors the 16-bit LSU word: [15]en [14]mode [13:10]stride [9:0]base
   typedef struct packed {
      logic       en;
      logic       mode;     // 0 = load, 1 = store
      logic [3:0] stride;
      logic [9:0] base;
   } lsu_cfg_t;

   typedef enum logic [1:0] {
      SEQ_IDLE  = 2'd0,
      SEQ_RUN   = 2'd1,
      SEQ_DRAIN = 2'd2
   } seq_state_e;

   // (base + idx*stride) mod SPM_DEPTH; wrap falls out of the A_W-bit sum
   function automatic logic [A_W-1:0] lsu_addr(input lsu_cfg_t cfg,
                                               input logic [IDX_W-1:0] idx);
      logic [IDX_W+3:0] prod;
      prod = {4'b0, idx} * {{IDX_W{1'b0}}, cfg.stride};
      return cfg.base + prod[A_W-1:0];
   endfunction

endpackage

// File: rtl/tcad_pe.sv
// rtl/tcad_pe.sv - combinational processing element of the tcad_array
//
// Purpose : y = op(x, imm) selected by the PE configuration word
//           ([3:0] op, [47:16] imm). Unused opcodes pass x through.
// Ports   : i_x   [DATA_W-1:0]    operand from the previous PE / row input
//           i_cfg [PE_INST_W-1:0] configuration word
//           o_y   [DATA_W-1:0]    result, mod 2^32

module tcad_pe
   import tcad_array_pkg::*;
(
   input  logic [DATA_W-1:0]    i_x,
   input  logic [PE_INST_W-1:0] i_cfg,
   output logic [DATA_W-1:0]    o_y
);

   logic [DATA_W-1:0] w_imm;
   logic [4:0]        w_sh;
   logic [DATA_W-1:0] w_mul;
   logic              w_unused_cfg;

   assign w_imm        = i_cfg[47:16];
   assign w_sh         = w_imm[4:0];
   assign w_mul        = i_x * w_imm;
   assign w_unused_cfg = ^i_cfg[15:4];

   always_comb begin
      o_y = i_x;
      case (pe_op_e'(i_cfg[3:0]))
         OP_ADD:  o_y = i_x + w_imm;
         OP_SUB:  o_y = i_x - w_imm;
         OP_MUL:  o_y = w_mul;
         OP_AND:  o_y = i_x & w_imm;
         OP_OR:   o_y = i_x | w_imm;
         OP_XOR:  o_y = i_x ^ w_imm;
         OP_SHL:  o_y = i_x << w_sh;
         OP_SHR:  o_y = i_x >> w_sh;
         default: o_y = i_x;
      endcase
   end

endmodule

// File: rtl/tcad_array.sv
// rtl/tcad_array.sv - 4x4 CGRA compute core with per-row LSU, 1024x32 SPM and run sequencer
//
// Purpose : host loads PE/LSU/SPM-control configuration while idle, streams SPM data over
//           ex_bus, and a run pulse pushes N iterations through the four row stages.
// Ports   : clk             clock, rising edge
//           rst             synchronous active-high reset
//           host_controller [58]run [57]init_SPM [56:53]init_row [52]init_LSU [51:48]init_PE [47:0]inst
//           ex_bus          [43]wen [42]ren [41:32]addr [31:0]data
//           TCAD_result     registered row-3 result or SPM read-back

module tcad_array
   import tcad_array_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [HC_W-1:0]   host_controller,
   input  logic [EX_W-1:0]   ex_bus,
   output logic [DATA_W-1:0] TCAD_result
);

   // ---------------- input decode ----------------
   logic                 w_run;
   logic                 w_init_spm;
   logic [ROWS-1:0]      w_init_row;
   logic                 w_init_lsu;
   logic [COLS-1:0]      w_init_pe;
   logic [PE_INST_W-1:0] w_inst;
   logic                 w_ex_wen;
   logic                 w_ex_ren;
   logic [A_W-1:0]       w_ex_addr;
   logic [DATA_W-1:0]    w_ex_data;

   assign w_run      = host_controller[HC_RUN];
   assign w_init_spm = host_controller[HC_INIT_SPM];
   assign w_init_row = host_controller[HC_ROW_LSB +: ROWS];
   assign w_init_lsu = host_controller[HC_INIT_LSU];
   assign w_init_pe  = host_controller[HC_PE_LSB +: COLS];
   assign w_inst     = host_controller[PE_INST_W-1:0];
   assign w_ex_wen   = ex_bus[EX_WEN];
   assign w_ex_ren   = ex_bus[EX_REN];
   assign w_ex_addr  = ex_bus[EX_ADDR_LSB +: A_W];
   assign w_ex_data  = ex_bus[DATA_W-1:0];

   // ---------------- state ----------------
   logic [PE_INST_W-1:0]  r_pe_cfg  [ROWS][COLS];
   lsu_cfg_t              r_lsu_cfg [ROWS];
   logic [SPM_CTRL_W-1:0] r_spm_ctrl;

   seq_state_e            r_state;
   logic [IDX_W-1:0]      r_iter;
   logic                  r_seq_valid;
   logic [IDX_W-1:0]      r_seq_idx;

   logic [ROWS-1:0]       r_valid;
   logic [IDX_W-1:0]      r_idx     [ROWS];
   logic [DATA_W-1:0]     r_row_out [ROWS];
   logic [DATA_W-1:0]     r_result;

   logic [DATA_W-1:0]     r_spm     [SPM_DEPTH];

   logic [IDX_W-1:0]      w_n;
   logic                  w_unused_ctrl;

   assign w_n           = r_spm_ctrl[IDX_W-1:0];
   assign w_unused_ctrl = ^r_spm_ctrl[SPM_CTRL_W-1:IDX_W];

   // ---------------- configuration registers ----------------
   // Loads are only honoured while idle so a running kernel never sees a
   // half-updated configuration.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
               r_pe_cfg[r][c] <= '0;
            end
            r_lsu_cfg[r] <= '0;
         end
         r_spm_ctrl <= '0;
      end else if (r_state == SEQ_IDLE) begin
         for (int r = 0; r < ROWS; r++) begin
            if (w_init_row[r]) begin
               for (int c = 0; c < COLS; c++) begin
                  if (w_init_pe[c]) begin
                     r_pe_cfg[r][c] <= w_inst;
                  end
               end
               if (w_init_lsu) begin
                  r_lsu_cfg[r] <= lsu_cfg_t'(w_inst[LSU_W-1:0]);
               end
            end
         end
         if (w_init_spm) begin
            r_spm_ctrl <= w_inst[SPM_CTRL_W-1:0];
         end
      end
   end

   // ---------------- run sequencer ----------------
   // Issue (r_seq_valid/r_seq_idx) is registered, so iteration k enters row 0
   // one cycle after it is issued. DRAIN waits for the issue register as well
   // as the row pipeline so the last iteration is never cut short.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= SEQ_IDLE;
         r_iter      <= '0;
         r_seq_valid <= 1'b0;
         r_seq_idx   <= '0;
      end else begin
         case (r_state)
            SEQ_IDLE: begin
               r_seq_valid <= 1'b0;
               if (w_run && (w_n != '0)) begin
                  r_state <= SEQ_RUN;
                  r_iter  <= '0;
               end
            end
            SEQ_RUN: begin
               r_seq_valid <= 1'b1;
               r_seq_idx   <= r_iter;
               r_iter      <= r_iter + 8'd1;
               if (r_iter == (w_n - 8'd1)) begin
                  r_state <= SEQ_DRAIN;
               end
            end
            SEQ_DRAIN: begin
               r_seq_valid <= 1'b0;
               if (!r_seq_valid && (r_valid == '0)) begin
                  r_state <= SEQ_IDLE;
               end
            end
            default: begin
               r_state     <= SEQ_IDLE;
               r_seq_valid <= 1'b0;
            end
         endcase
      end
   end

   // ---------------- row datapath ----------------
   logic [ROWS-1:0]   w_valid_in;
   logic [IDX_W-1:0]  w_idx_in   [ROWS];
   logic [DATA_W-1:0] w_row_next [ROWS];
   logic [A_W-1:0]    w_st_addr  [ROWS];
   logic [ROWS-1:0]   w_st_en;

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      logic [DATA_W-1:0] w_prev;
      logic [DATA_W-1:0] w_chain [COLS+1];
      logic [A_W-1:0]    w_ld_addr;
      logic              w_load;

      if (r == 0) begin : g_first
         assign w_valid_in[r] = r_seq_valid;
         assign w_idx_in[r]   = r_seq_idx;
         assign w_prev        = '0;
      end else begin : g_next
         assign w_valid_in[r] = r_valid[r-1];
         assign w_idx_in[r]   = r_idx[r-1];
         assign w_prev        = r_row_out[r-1];
      end

      // A loading row replaces the value flowing down from the row above.
      assign w_load     = r_lsu_cfg[r].en && !r_lsu_cfg[r].mode;
      assign w_ld_addr  = lsu_addr(r_lsu_cfg[r], w_idx_in[r]);
      assign w_chain[0] = w_load ? r_spm[w_ld_addr] : w_prev;

      for (genvar c = 0; c < COLS; c++) begin : g_col
         tcad_pe u_pe (
            .i_x   (w_chain[c]),
            .i_cfg (r_pe_cfg[r][c]),
            .o_y   (w_chain[c+1])
         );
      end

      assign w_row_next[r] = w_chain[COLS];

      // Stores use the row's own registered result and index, one cycle after compute.
      assign w_st_addr[r] = lsu_addr(r_lsu_cfg[r], r_idx[r]);
      assign w_st_en[r]   = r_valid[r] && r_lsu_cfg[r].en && r_lsu_cfg[r].mode;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= '0;
         for (int r = 0; r < ROWS; r++) begin
            r_idx[r]     <= '0;
            r_row_out[r] <= '0;
         end
      end else begin
         r_valid <= w_valid_in;
         for (int r = 0; r < ROWS; r++) begin
            r_idx[r]     <= w_idx_in[r];
            r_row_out[r] <= w_row_next[r];
         end
      end
   end

   // ---------------- scratchpad ----------------
   // Later assignments win: ex_bus write is lowest priority, row 3 highest.
   // Row stores are gated by rst so the reset edge itself commits nothing.
   always_ff @(posedge clk) begin
      if (w_ex_wen) begin
         r_spm[w_ex_addr] <= w_ex_data;
      end
      if (!rst) begin
         for (int r = 0; r < ROWS; r++) begin
            if (w_st_en[r]) begin
               r_spm[w_st_addr[r]] <= r_row_out[r];
            end
         end
      end
   end

   // ---------------- result register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_result <= '0;
      end else if (r_valid[ROWS-1]) begin
         r_result <= r_row_out[ROWS-1];
      end else if (w_ex_ren) begin
         r_result <= r_spm[w_ex_addr];
      end
   end

   assign TCAD_result = r_result;

endmodule

// File: tb/tb_tcad_array.sv
// tb/tb_tcad_array.sv - self-checking bench for tcad_array with a behavioural reference model

module tb_tcad_array;

   logic        clk = 1'b0;
   logic        rst;
   logic [58:0] host_controller;
   logic [43:0] ex_bus;
   logic [31:0] TCAD_result;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   tcad_array dut (
      .clk             (clk),
      .rst             (rst),
      .host_controller (host_controller),
      .ex_bus          (ex_bus),
      .TCAD_result     (TCAD_result)
   );

   // reference model state
   logic [47:0] m_pe  [16];
   logic [15:0] m_lsu [4];
   logic [7:0]  m_n;
   logic [31:0] m_spm [1024];
   logic [31:0] exp_q[$];
   int          st_addr_q[$];
   logic [31:0] st_data_q[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [47:0] mk_pe(input int op, input logic [31:0] imm);
      logic [3:0] o;
      o = 4'(op);
      return {imm, 12'h000, o};
   endfunction

   function automatic logic [15:0] mk_lsu(input bit en, input bit mode, input int stride, input int base);
      logic [3:0] s;
      logic [9:0] b;
      s = 4'(stride);
      b = 10'(base);
      return {en, mode, s, b};
   endfunction

   function automatic logic [31:0] ref_pe(input logic [47:0] w, input logic [31:0] x);
      logic [31:0] imm;
      imm = w[47:16];
      case (int'(w[3:0]))
         1: return x + imm;
         2: return x - imm;
         3: return x * imm;
         4: return x & imm;
         5: return x | imm;
         6: return x ^ imm;
         7: return x << imm[4:0];
         8: return x >> imm[4:0];
         default: return x;
      endcase
   endfunction

   function automatic int ref_addr(input logic [15:0] l, input int idx);
      return (int'(l[9:0]) + idx * int'(l[13:10])) % 1024;
   endfunction

   // Whole-iteration view: each iteration flows row 0..3, loads replace the value, stores record it.
   task automatic build_expect(input int n);
      logic [31:0] x;
      exp_q.delete();
      st_addr_q.delete();
      st_data_q.delete();
      for (int k = 0; k < n; k++) begin
         x = 32'h0;
         for (int r = 0; r < 4; r++) begin
            if (m_lsu[r][15] && !m_lsu[r][14]) x = m_spm[ref_addr(m_lsu[r], k)];
            for (int c = 0; c < 4; c++) x = ref_pe(m_pe[r*4+c], x);
            if (m_lsu[r][15] && m_lsu[r][14]) begin
               st_addr_q.push_back(ref_addr(m_lsu[r], k));
               st_data_q.push_back(x);
            end
         end
         exp_q.push_back(x);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      host_controller = '0;
      ex_bus = '0;
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 16; i++) m_pe[i] = '0;
      for (int i = 0; i < 4; i++) m_lsu[i] = '0;
      m_n = '0;
   endtask

   task automatic ex_write(input int addr, input logic [31:0] data);
      ex_bus = {1'b1, 1'b0, 10'(addr), data};
      tick();
      ex_bus = '0;
      m_spm[addr] = data;
   endtask

   task automatic ex_read(input int addr, output logic [31:0] val);
      ex_bus = {1'b0, 1'b1, 10'(addr), 32'h0};
      tick();
      val = TCAD_result;
      ex_bus = '0;
   endtask

   task automatic cfg_pe_mask(input logic [3:0] rmask, input logic [3:0] cmask, input logic [47:0] inst);
      host_controller = '0;
      host_controller[56:53] = rmask;
      host_controller[51:48] = cmask;
      host_controller[47:0] = inst;
      tick();
      host_controller = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (rmask[r] && cmask[c]) m_pe[r*4+c] = inst;
   endtask

   task automatic cfg_pe(input int r, input int c, input logic [47:0] inst);
      logic [3:0] rm;
      logic [3:0] cm;
      rm = 4'b0001 << r;
      cm = 4'b0001 << c;
      cfg_pe_mask(rm, cm, inst);
   endtask

   task automatic cfg_lsu(input int r, input logic [15:0] w);
      host_controller = '0;
      host_controller[53+r] = 1'b1;
      host_controller[52] = 1'b1;
      host_controller[15:0] = w;
      tick();
      host_controller = '0;
      m_lsu[r] = w;
   endtask

   task automatic cfg_n(input logic [7:0] n);
      host_controller = '0;
      host_controller[57] = 1'b1;
      host_controller[7:0] = n;
      tick();
      host_controller = '0;
      m_n = n;
   endtask

   task automatic run_pulse();
      host_controller = '0;
      host_controller[58] = 1'b1;
      tick();
      host_controller = '0;
   endtask

   task automatic run_check(input string name, input bit use_d, input logic [31:0] d0);
      int n;
      logic [31:0] v;
      n = int'(m_n);
      build_expect(n);
      run_pulse();
      repeat (6) tick();
      for (int k = 0; k < n; k++) begin
         checks++;
         if (TCAD_result !== exp_q[k]) begin
            errors++;
            $display("FAIL %s result[%0d]: got %h expected %h", name, k, TCAD_result, exp_q[k]);
         end
         if (k == 0 && use_d) begin
            checks++;
            if (TCAD_result !== d0) begin
               errors++;
               $display("FAIL %s directed: got %h expected %h", name, TCAD_result, d0);
            end
         end
         tick();
      end
      checks++;
      if (TCAD_result !== exp_q[n-1]) begin
         errors++;
         $display("FAIL %s hold: got %h expected %h", name, TCAD_result, exp_q[n-1]);
      end
      repeat (2) tick();
      for (int i = 0; i < st_addr_q.size(); i++) m_spm[st_addr_q[i]] = st_data_q[i];
      for (int i = 0; i < st_addr_q.size(); i++) begin
         ex_read(st_addr_q[i], v);
         checks++;
         if (v !== m_spm[st_addr_q[i]]) begin
            errors++;
            $display("FAIL %s store[%h]: got %h expected %h", name, st_addr_q[i], v, m_spm[st_addr_q[i]]);
         end
      end
      repeat (2) tick();
   endtask

   task automatic test_reset();
      logic [31:0] v;
      do_reset();
      checks++;
      if (TCAD_result !== 32'h0) begin
         errors++;
         $display("FAIL reset_initial: got %h expected 0", TCAD_result);
      end
      ex_write(9, 32'hFEED_0009);
      ex_read(9, v);
      do_reset();
      checks++;
      if (TCAD_result !== 32'h0) begin
         errors++;
         $display("FAIL reset_clears_result: got %h expected 0", TCAD_result);
      end
   endtask

   task automatic test_ex_rw();
      logic [31:0] v;
      int a [4];
      ex_write(5, 32'h1234);
      ex_read(5, v);
      checks++;
      if (v !== 32'h1234) begin
         errors++;
         $display("FAIL ex_rw_5: got %h expected 00001234", v);
      end
      for (int i = 0; i < 4; i++) begin
         a[i] = 32 + i * 97 + int'($urandom_range(0, 90));
         ex_write(a[i], $urandom);
      end
      for (int i = 0; i < 4; i++) begin
         ex_read(a[i], v);
         checks++;
         if (v !== m_spm[a[i]]) begin
            errors++;
            $display("FAIL ex_rw_rand[%h]: got %h expected %h", a[i], v, m_spm[a[i]]);
         end
      end
   endtask

   task automatic test_basic_flow();
      logic [31:0] v;
      do_reset();
      for (int i = 0; i < 4; i++) ex_write(i, 32'(i + 1));
      for (int i = 0; i < 4; i++) ex_write(32'h100 + i, 32'hDEAD_0000);
      cfg_lsu(0, mk_lsu(1, 0, 1, 0));
      cfg_pe(0, 0, mk_pe(1, 32'd1));
      cfg_lsu(3, mk_lsu(1, 1, 1, 32'h100));
      cfg_n(8'd4);
      run_check("basic", 1'b1, 32'd2);
      ex_read(32'h103, v);
      checks++;
      if (v !== 32'd5) begin
         errors++;
         $display("FAIL basic_store_103: got %h expected 00000005", v);
      end
   endtask

   task automatic test_run_ignore();
      do_reset();
      cfg_lsu(0, mk_lsu(1, 0, 1, 0));
      cfg_pe(0, 0, mk_pe(1, 32'd1));
      cfg_n(8'd4);
      build_expect(4);
      run_pulse();
      tick();
      host_controller = '0;
      host_controller[58] = 1'b1;
      host_controller[53] = 1'b1;
      host_controller[48] = 1'b1;
      host_controller[47:0] = mk_pe(1, 32'd100);
      tick();
      host_controller = '0;
      repeat (4) tick();
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (TCAD_result !== exp_q[k]) begin
            errors++;
            $display("FAIL ignore_result[%0d]: got %h expected %h", k, TCAD_result, exp_q[k]);
         end
         tick();
      end
      for (int t = 0; t < 8; t++) begin
         checks++;
         if (TCAD_result !== 32'd5) begin
            errors++;
            $display("FAIL ignore_hold[%0d]: got %h expected 00000005", t, TCAD_result);
         end
         tick();
      end
   endtask

   task automatic test_n_zero();
      cfg_n(8'd0);
      run_pulse();
      repeat (10) tick();
      checks++;
      if (TCAD_result !== 32'd5) begin
         errors++;
         $display("FAIL n_zero_hold: got %h expected 00000005", TCAD_result);
      end
      cfg_n(8'd2);
      run_check("after_n_zero", 1'b1, 32'd2);
   endtask

   task automatic test_ops();
      do_reset();
      ex_write(32'h10, 32'h0001_0000);
      cfg_lsu(0, mk_lsu(1, 0, 0, 32'h10));
      cfg_pe(0, 0, mk_pe(3, 32'h0001_0000));
      cfg_n(8'd1);
      run_check("mul_wrap", 1'b1, 32'h0);
      do_reset();
      ex_write(32'h11, 32'h8000_0000);
      cfg_lsu(0, mk_lsu(1, 0, 0, 32'h11));
      cfg_pe(0, 1, mk_pe(8, 32'd4));
      cfg_n(8'd1);
      run_check("shr", 1'b1, 32'h0800_0000);
   endtask

   task automatic test_addr_wrap();
      do_reset();
      ex_write(32'h3FF, 32'hAAAA_0001);
      ex_write(32'h001, 32'h5555_0002);
      cfg_lsu(0, mk_lsu(1, 0, 2, 32'h3FF));
      cfg_n(8'd2);
      run_check("addr_wrap", 1'b1, 32'hAAAA_0001);
   endtask

   task automatic test_random();
      int mode;
      for (int a = 0; a < 256; a++) ex_write(a, $urandom);
      for (int round = 0; round < 6; round++) begin
         do_reset();
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               cfg_pe(r, c, mk_pe(int'($urandom_range(0, 15)), $urandom));
         cfg_pe_mask(4'($urandom_range(1, 15)), 4'($urandom_range(1, 15)),
                     mk_pe(int'($urandom_range(0, 15)), $urandom));
         cfg_lsu(0, mk_lsu(1, 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 127))));
         for (int r = 1; r < 3; r++) begin
            mode = int'($urandom_range(0, 2));
            if (mode == 0) cfg_lsu(r, mk_lsu(0, 1, 3, 0));
            else if (mode == 1) cfg_lsu(r, mk_lsu(1, 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 127))));
         end
         if ($urandom_range(0, 1) == 0)
            cfg_lsu(3, mk_lsu(1, 1, int'($urandom_range(0, 7)), 32'h200 + int'($urandom_range(0, 255))));
         else
            cfg_lsu(3, mk_lsu(1, 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 127))));
         cfg_n(8'($urandom_range(1, 8)));
         run_check("random", 1'b0, 32'h0);
      end
   endtask

   task automatic test_reset_mid_run();
      logic [31:0] v;
      logic [31:0] first;
      do_reset();
      for (int i = 0; i < 8; i++) ex_write(32'h300 + i, 32'hC0DE_0000 + 32'(i));
      cfg_lsu(0, mk_lsu(1, 0, 1, 0));
      cfg_pe(0, 0, mk_pe(1, 32'd7));
      cfg_lsu(3, mk_lsu(1, 1, 1, 32'h300));
      cfg_n(8'd8);
      build_expect(8);
      first = st_data_q[0];
      run_pulse();
      repeat (6) tick();
      checks++;
      if (TCAD_result !== exp_q[0]) begin
         errors++;
         $display("FAIL midrun_first: got %h expected %h", TCAD_result, exp_q[0]);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (TCAD_result !== 32'h0) begin
         errors++;
         $display("FAIL midrun_reset_result: got %h expected 0", TCAD_result);
      end
      repeat (10) tick();
      checks++;
      if (TCAD_result !== 32'h0) begin
         errors++;
         $display("FAIL midrun_squashed: got %h expected 0", TCAD_result);
      end
      ex_read(32'h300, v);
      checks++;
      if (v !== first) begin
         errors++;
         $display("FAIL midrun_store_300: got %h expected %h", v, first);
      end
      for (int i = 1; i < 8; i++) begin
         ex_read(32'h300 + i, v);
         checks++;
         if (v !== 32'hC0DE_0000 + 32'(i)) begin
            errors++;
            $display("FAIL midrun_nostore[%0d]: got %h expected %h", i, v, 32'hC0DE_0000 + 32'(i));
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      host_controller = '0;
      ex_bus = '0;
      test_reset();
      test_ex_rw();
      test_basic_flow();
      test_run_ignore();
      test_n_zero();
      test_ops();
      test_addr_wrap();
      test_random();
      test_reset_mid_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
